// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: turns EX/MEM access requests into handshaked
// data-memory transactions, formats load data and stalls the pipeline meanwhile.
module mem_stage_lsu #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_mem_rd_m,
   input  logic        i_mem_wr_m,
   input  logic [2:0]  i_f3_m,
   input  logic [31:0] i_alu_out_m,
   input  logic [31:0] i_wr_data_m,
   output logic [31:0] o_mem_out_m,
   output logic        o_stall,
   output logic        o_misaligned,
   output logic        o_bus_err,
   output logic        o_dmem_req,
   output logic        o_dmem_we,
   output logic [31:0] o_dmem_addr,
   output logic [31:0] o_dmem_wdata,
   output logic [3:0]  o_dmem_be,
   input  logic        i_dmem_ack,
   input  logic [31:0] i_dmem_rdata
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_BUSY = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;
   localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

   logic [1:0]  state_q, state_d;
   logic [7:0]  cnt_q, cnt_d;
   logic        req_q, req_d;
   logic        we_q, we_d;
   logic        err_q, err_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] mem_out_q, mem_out_d;
   logic [3:0]  be_q, be_d;
   logic [2:0]  f3_q, f3_d;
   logic [1:0]  off_q, off_d;

   logic        acc;
   logic        misaligned;
   logic [3:0]  st_be;
   logic [31:0] st_wdata;
   logic [31:0] load_data;
   logic [15:0] rd_half;
   logic [7:0]  rd_byte [4];

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_lane
         assign rd_byte[gi] = i_dmem_rdata[8*gi +: 8];
      end
   endgenerate

   always_comb begin
      acc        = i_mem_rd_m | i_mem_wr_m;
      misaligned = 1'b0;
      case (i_f3_m[1:0])
         2'b01:   misaligned = i_alu_out_m[0];
         2'b10:   misaligned = |i_alu_out_m[1:0];
         default: misaligned = 1'b0;
      endcase
      // Loads always fetch the whole word; stores steer data onto the addressed lanes
      st_be    = 4'b1111;
      st_wdata = i_wr_data_m;
      if (i_mem_wr_m) begin
         case (i_f3_m[1:0])
            2'b00: begin
               st_be    = 4'b0001 << i_alu_out_m[1:0];
               st_wdata = {4{i_wr_data_m[7:0]}};
            end
            2'b01: begin
               st_be    = i_alu_out_m[1] ? 4'b1100 : 4'b0011;
               st_wdata = {2{i_wr_data_m[15:0]}};
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      rd_half = off_q[1] ? i_dmem_rdata[31:16] : i_dmem_rdata[15:0];
      case (f3_q)
         3'b000:  load_data = {{24{rd_byte[off_q][7]}}, rd_byte[off_q]};
         3'b001:  load_data = {{16{rd_half[15]}}, rd_half};
         3'b100:  load_data = {24'b0, rd_byte[off_q]};
         3'b101:  load_data = {16'b0, rd_half};
         default: load_data = i_dmem_rdata;
      endcase
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      req_d     = req_q;
      we_d      = we_q;
      err_d     = 1'b0;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      mem_out_d = mem_out_q;
      be_d      = be_q;
      f3_d      = f3_q;
      off_d     = off_q;
      case (state_q)
         S_IDLE: begin
            if (acc && !misaligned) begin
               addr_d  = {i_alu_out_m[31:2], 2'b00};
               off_d   = i_alu_out_m[1:0];
               be_d    = st_be;
               wdata_d = st_wdata;
               we_d    = i_mem_wr_m;
               f3_d    = i_f3_m;
               req_d   = 1'b1;
               cnt_d   = 8'd0;
               state_d = S_BUSY;
            end
         end
         S_BUSY: begin
            cnt_d = cnt_q + 8'd1;
            // A late ack coinciding with the last allowed cycle still completes normally
            if (i_dmem_ack) begin
               mem_out_d = we_q ? 32'd0 : load_data;
               req_d     = 1'b0;
               cnt_d     = 8'd0;
               state_d   = S_DONE;
            end else if (cnt_q == CNT_LAST) begin
               mem_out_d = 32'd0;
               err_d     = 1'b1;
               req_d     = 1'b0;
               cnt_d     = 8'd0;
               state_d   = S_DONE;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q   <= S_IDLE;
         cnt_q     <= 8'd0;
         req_q     <= 1'b0;
         we_q      <= 1'b0;
         err_q     <= 1'b0;
         addr_q    <= 32'd0;
         wdata_q   <= 32'd0;
         mem_out_q <= 32'd0;
         be_q      <= 4'd0;
         f3_q      <= 3'd0;
         off_q     <= 2'd0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         req_q     <= req_d;
         we_q      <= we_d;
         err_q     <= err_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         mem_out_q <= mem_out_d;
         be_q      <= be_d;
         f3_q      <= f3_d;
         off_q     <= off_d;
      end
   end

   assign o_misaligned = acc & misaligned;
   assign o_stall      = ((state_q == S_IDLE) & acc & ~misaligned) | (state_q == S_BUSY);
   assign o_mem_out_m  = mem_out_q;
   assign o_bus_err    = err_q;
   assign o_dmem_req   = req_q;
   assign o_dmem_we    = we_q;
   assign o_dmem_addr  = addr_q;
   assign o_dmem_wdata = wdata_q;
   assign o_dmem_be    = be_q;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Bench for mem_stage_lsu: directed vector table, random accesses against a
// behavioural model, plus timeout and asynchronous-reset sequences.
module tb_mem_stage_lsu;

   localparam int TMO = 4;

   logic        i_clk = 1'b0;
   logic        i_rst;
   logic        i_mem_rd_m, i_mem_wr_m;
   logic [2:0]  i_f3_m;
   logic [31:0] i_alu_out_m, i_wr_data_m;
   logic [31:0] o_mem_out_m;
   logic        o_stall, o_misaligned, o_bus_err;
   logic        o_dmem_req, o_dmem_we;
   logic [31:0] o_dmem_addr, o_dmem_wdata;
   logic [3:0]  o_dmem_be;
   logic        i_dmem_ack;
   logic [31:0] i_dmem_rdata;

   int checks = 0;
   int errors = 0;
   logic [31:0] last_out = 32'd0;

   typedef struct {
      logic        rd;
      logic        wr;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] wd;
      logic [31:0] rdata;
      int          ack_dly;
      logic [31:0] exp_out;
      logic [3:0]  exp_be;
      logic [31:0] exp_wd;
      logic        exp_mis;
   } vec_t;

   vec_t tbl [13];

   mem_stage_lsu #(.TIMEOUT_CYCLES(TMO)) dut (
      .i_clk        (i_clk),
      .i_rst        (i_rst),
      .i_mem_rd_m   (i_mem_rd_m),
      .i_mem_wr_m   (i_mem_wr_m),
      .i_f3_m       (i_f3_m),
      .i_alu_out_m  (i_alu_out_m),
      .i_wr_data_m  (i_wr_data_m),
      .o_mem_out_m  (o_mem_out_m),
      .o_stall      (o_stall),
      .o_misaligned (o_misaligned),
      .o_bus_err    (o_bus_err),
      .o_dmem_req   (o_dmem_req),
      .o_dmem_we    (o_dmem_we),
      .o_dmem_addr  (o_dmem_addr),
      .o_dmem_wdata (o_dmem_wdata),
      .o_dmem_be    (o_dmem_be),
      .i_dmem_ack   (i_dmem_ack),
      .i_dmem_rdata (i_dmem_rdata)
   );

   always #5 i_clk = ~i_clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", nm, act, exp);
      end
   endtask

   // Behavioural model: sizes in bytes, arithmetic on integers
   function automatic int unsigned st_size(input logic [2:0] f3);
      case (f3[1:0])
         2'b00:   return 1;
         2'b01:   return 2;
         default: return 4;
      endcase
   endfunction

   function automatic logic ref_mis(input logic [2:0] f3, input logic [31:0] addr);
      int unsigned a;
      a = 1;
      if (f3[1:0] == 2'b01) a = 2;
      if (f3[1:0] == 2'b10) a = 4;
      return (addr % a) != 0;
   endfunction

   function automatic logic [3:0] ref_be(input logic st, input logic [2:0] f3, input logic [31:0] addr);
      int unsigned sz, off;
      if (!st) return 4'hF;
      sz  = st_size(f3);
      off = (addr % 4) - ((addr % 4) % sz);
      return 4'(((1 << sz) - 1) << off);
   endfunction

   function automatic logic [31:0] ref_wd(input logic [2:0] f3, input logic [31:0] wd);
      longint unsigned v, r;
      int unsigned sz;
      sz = st_size(f3);
      v  = longint'(wd) % (64'd1 << (8 * sz));
      r  = 0;
      for (int k = 0; k < 4 / sz; k++) r = r + (v << (8 * sz * k));
      return r[31:0];
   endfunction

   function automatic logic [31:0] ref_ld(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] rdata);
      longint v;
      int sz, sh;
      bit sgn;
      case (f3)
         3'b000:  begin sz = 1; sgn = 1; end
         3'b001:  begin sz = 2; sgn = 1; end
         3'b100:  begin sz = 1; sgn = 0; end
         3'b101:  begin sz = 2; sgn = 0; end
         default: begin sz = 4; sgn = 0; end
      endcase
      sh = (sz == 4) ? 0 : 8 * int'(addr % 4);
      v  = (longint'(rdata) >> sh) % (64'sd1 << (8 * sz));
      if (sgn && v >= (64'sd1 << (8 * sz - 1))) v = v - (64'sd1 << (8 * sz));
      return 32'(v);
   endfunction

   task automatic set_idle();
      i_mem_rd_m  = 1'b0;
      i_mem_wr_m  = 1'b0;
      i_dmem_ack  = 1'b0;
   endtask

   // Called at a negedge with the FSM idle; returns at the negedge of the following idle cycle.
   task automatic run_access(input vec_t v, input string nm);
      int stall_n, req_n, exp_stall, exp_req;
      bit tmo, done;
      logic [31:0] exp_out;
      i_mem_rd_m   = v.rd;
      i_mem_wr_m   = v.wr;
      i_f3_m       = v.f3;
      i_alu_out_m  = v.addr;
      i_wr_data_m  = v.wd;
      i_dmem_ack   = 1'b0;
      i_dmem_rdata = $urandom();
      #1;
      chk({nm, ".misaligned"}, 32'(o_misaligned), 32'(v.exp_mis));
      if (v.exp_mis) begin
         chk({nm, ".mis_stall"}, 32'(o_stall), 32'd0);
         @(posedge i_clk);
         @(negedge i_clk);
         chk({nm, ".mis_req"}, 32'(o_dmem_req), 32'd0);
         chk({nm, ".mis_stall2"}, 32'(o_stall), 32'd0);
         chk({nm, ".mis_out"}, o_mem_out_m, last_out);
         $display("txn %s misaligned addr=%h out=%h", nm, v.addr, o_mem_out_m);
         return;
      end
      chk({nm, ".stall_req_cycle"}, 32'(o_stall), 32'd1);
      tmo     = v.ack_dly >= TMO;
      stall_n = 1;
      req_n   = 0;
      done    = 0;
      @(posedge i_clk);
      for (int k = 0; k < 300; k++) begin
         @(negedge i_clk);
         if (!o_stall) begin
            done = 1;
            break;
         end
         stall_n++;
         if (o_dmem_req) req_n++;
         chk({nm, ".addr"}, o_dmem_addr, v.addr & 32'hFFFF_FFFC);
         chk({nm, ".be"}, 32'(o_dmem_be), 32'(v.exp_be));
         chk({nm, ".we"}, 32'(o_dmem_we), 32'(v.wr));
         if (v.wr) chk({nm, ".wdata"}, o_dmem_wdata, v.exp_wd);
         if (k == v.ack_dly) begin
            i_dmem_ack   = 1'b1;
            i_dmem_rdata = v.rdata;
         end else begin
            i_dmem_ack   = 1'b0;
            i_dmem_rdata = $urandom();
         end
      end
      i_dmem_ack = 1'b0;
      exp_out   = tmo ? 32'd0 : v.exp_out;
      exp_stall = tmo ? TMO + 1 : v.ack_dly + 2;
      exp_req   = tmo ? TMO : v.ack_dly + 1;
      chk({nm, ".done_reached"}, 32'(done), 32'd1);
      chk({nm, ".stall_cycles"}, 32'(stall_n), 32'(exp_stall));
      chk({nm, ".req_cycles"}, 32'(req_n), 32'(exp_req));
      chk({nm, ".done_req"}, 32'(o_dmem_req), 32'd0);
      chk({nm, ".mem_out"}, o_mem_out_m, exp_out);
      chk({nm, ".bus_err"}, 32'(o_bus_err), 32'(tmo));
      last_out = exp_out;
      @(posedge i_clk);
      @(negedge i_clk);
      chk({nm, ".bus_err_clear"}, 32'(o_bus_err), 32'd0);
      $display("txn %s rd=%0b wr=%0b f3=%0d addr=%h out=%h stall=%0d tmo=%0b",
               nm, v.rd, v.wr, v.f3, v.addr, exp_out, stall_n, tmo);
   endtask

   initial begin
      vec_t rv;
      int r;
      tbl[0]  = '{1'b1, 1'b0, 3'd0, 32'h103, 32'h0,        32'h80FF_1234, 0, 32'hFFFF_FF80, 4'hF, 32'h0,        1'b0};
      tbl[1]  = '{1'b1, 1'b0, 3'd2, 32'h301, 32'h0,        32'h0,         0, 32'h0,         4'hF, 32'h0,        1'b1};
      tbl[2]  = '{1'b0, 1'b1, 3'd1, 32'h202, 32'h0000_BEEF, 32'h0,        1, 32'h0,         4'hC, 32'hBEEF_BEEF, 1'b0};
      tbl[3]  = '{1'b1, 1'b0, 3'd4, 32'h101, 32'h0,        32'h1234_5678, 3, 32'h0000_0056, 4'hF, 32'h0,        1'b0};
      tbl[4]  = '{1'b1, 1'b0, 3'd5, 32'h402, 32'h0,        32'h9ABC_5678, 3, 32'h0000_9ABC, 4'hF, 32'h0,        1'b0};
      tbl[5]  = '{1'b1, 1'b0, 3'd1, 32'h406, 32'h0,        32'h8001_7FFF, 2, 32'hFFFF_8001, 4'hF, 32'h0,        1'b0};
      tbl[6]  = '{1'b1, 1'b0, 3'd1, 32'h701, 32'h0,        32'h0,         0, 32'h0,         4'hF, 32'h0,        1'b1};
      tbl[7]  = '{1'b0, 1'b1, 3'd0, 32'h503, 32'h1234_56A5, 32'h0,        0, 32'h0,         4'h8, 32'hA5A5_A5A5, 1'b0};
      tbl[8]  = '{1'b0, 1'b1, 3'd2, 32'h600, 32'hDEAD_BEEF, 32'h0,        1, 32'h0,         4'hF, 32'hDEAD_BEEF, 1'b0};
      tbl[9]  = '{1'b1, 1'b1, 3'd2, 32'h804, 32'h1122_3344, 32'h5555_5555, 0, 32'h0,        4'hF, 32'h1122_3344, 1'b0};
      tbl[10] = '{1'b1, 1'b0, 3'd0, 32'h100, 32'h0,        32'h0000_007F, 1, 32'h0000_007F, 4'hF, 32'h0,        1'b0};
      tbl[11] = '{1'b1, 1'b0, 3'd3, 32'h902, 32'h0,        32'hCAFE_F00D, 0, 32'hCAFE_F00D, 4'hF, 32'h0,        1'b0};
      tbl[12] = '{1'b1, 1'b0, 3'd2, 32'hB00, 32'h0,        32'h0000_1234, 6, 32'h0,         4'hF, 32'h0,        1'b0};

      i_rst        = 1'b1;
      i_f3_m       = 3'd0;
      i_alu_out_m  = 32'd0;
      i_wr_data_m  = 32'd0;
      i_dmem_rdata = 32'd0;
      set_idle();
      repeat (2) @(negedge i_clk);
      chk("reset.req", 32'(o_dmem_req), 32'd0);
      chk("reset.stall", 32'(o_stall), 32'd0);
      chk("reset.mem_out", o_mem_out_m, 32'd0);
      chk("reset.bus_err", 32'(o_bus_err), 32'd0);
      chk("reset.be", 32'(o_dmem_be), 32'd0);
      i_rst = 1'b0;
      @(negedge i_clk);

      for (int i = 0; i < 13; i++) run_access(tbl[i], $sformatf("vec%0d", i));

      // Ack after a timeout abort must not revive anything
      set_idle();
      i_dmem_ack   = 1'b1;
      i_dmem_rdata = 32'hFFFF_FFFF;
      repeat (2) @(negedge i_clk);
      chk("late_ack.req", 32'(o_dmem_req), 32'd0);
      chk("late_ack.stall", 32'(o_stall), 32'd0);
      chk("late_ack.mem_out", o_mem_out_m, 32'd0);
      chk("late_ack.bus_err", 32'(o_bus_err), 32'd0);
      i_dmem_ack = 1'b0;
      last_out   = 32'd0;

      for (int i = 0; i < 40; i++) begin
         r          = int'($urandom_range(1, 3));
         rv.rd      = r[0];
         rv.wr      = r[1];
         rv.f3      = 3'($urandom_range(0, 7));
         rv.addr    = $urandom();
         rv.wd      = $urandom();
         rv.rdata   = $urandom();
         rv.ack_dly = ($urandom_range(0, 9) == 0) ? TMO + 2 : int'($urandom_range(0, 4));
         rv.exp_mis = ref_mis(rv.f3, rv.addr);
         rv.exp_be  = ref_be(rv.wr, rv.f3, rv.addr);
         rv.exp_wd  = ref_wd(rv.f3, rv.wd);
         rv.exp_out = rv.wr ? 32'd0 : ref_ld(rv.f3, rv.addr, rv.rdata);
         run_access(rv, $sformatf("rnd%0d", i));
      end

      // Asynchronous reset in the middle of a BUSY access
      i_mem_rd_m  = 1'b1;
      i_mem_wr_m  = 1'b0;
      i_f3_m      = 3'd2;
      i_alu_out_m = 32'hA04;
      i_dmem_ack  = 1'b0;
      repeat (2) begin
         @(posedge i_clk);
         @(negedge i_clk);
      end
      chk("arst.req_before", 32'(o_dmem_req), 32'd1);
      #2;
      i_rst      = 1'b1;
      i_mem_rd_m = 1'b0;
      #1;
      chk("arst.req", 32'(o_dmem_req), 32'd0);
      chk("arst.stall", 32'(o_stall), 32'd0);
      chk("arst.addr", o_dmem_addr, 32'd0);
      chk("arst.mem_out", o_mem_out_m, 32'd0);
      chk("arst.we_be", {27'd0, o_dmem_we, o_dmem_be}, 32'd0);
      chk("arst.wdata_err", o_dmem_wdata | 32'(o_bus_err), 32'd0);
      @(negedge i_clk);
      i_rst      = 1'b0;
      i_dmem_ack = 1'b1;
      @(negedge i_clk);
      @(negedge i_clk);
      chk("arst.no_retry", 32'(o_dmem_req), 32'd0);
      chk("arst.idle_stall", 32'(o_stall), 32'd0);
      i_dmem_ack = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
